// File: rtl/audio_adc_i2s_receiver.sv
// I2S receiver for the WM8731 ADC path with the codec as slave: generates BCLK/ADCLRCK from MCLK,
// deserialises left/right words and queues {left, right, mono} pairs for a valid/ready consumer.
module audio_adc_i2s_receiver #(
   parameter int BCLK_DIV   = 8,
   parameter int SLOT_BITS  = 16,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          AUD_ADCDAT,
   output logic                          AUD_BCLK,
   output logic                          AUD_ADCLRCK,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_left,
   output logic [DATA_W-1:0]             out_right,
   output logic [DATA_W-1:0]             out_mono,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   localparam int DIV_W = $clog2(BCLK_DIV);
   localparam int BIT_W = $clog2(2 * SLOT_BITS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(BCLK_DIV / 2);
   localparam logic [DIV_W-1:0] DIV_SAMPLE = DIV_W'(3 * BCLK_DIV / 4);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT_BITS - 1);
   localparam logic [BIT_W-1:0] SLOT_POS   = BIT_W'(SLOT_BITS);
   localparam logic [BIT_W-1:0] DATA_POS   = BIT_W'(DATA_W);
   localparam logic [LVL_W-1:0] DEPTH_LVL  = LVL_W'(FIFO_DEPTH);
   localparam bit               LSB_WRAPS  = (DATA_W == SLOT_BITS);

   // Mono mix: 17-bit signed sum, arithmetic shift right by one (rounds toward -inf).
   function automatic logic [DATA_W-1:0] mono_mix(input logic signed [DATA_W-1:0] l,
                                                  input logic signed [DATA_W-1:0] r);
      logic signed [DATA_W:0] sum;
      sum = (DATA_W+1)'(l) + (DATA_W+1)'(r);
      return sum[DATA_W:1];
   endfunction

   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              bclk_q, lrck_q;
   logic              warm_q, warm_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] left_q;
   logic [DATA_W-1:0] mem_l_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_r_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_m_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [LVL_W-1:0]  count_q, count_d;
   logic              valid_q, ovf_q, ovf_d;
   logic [DATA_W-1:0] out_l_q, out_r_q, out_m_q;
   logic [DATA_W-1:0] head_l, head_r, head_m, mono_w;
   logic [BIT_W-1:0]  pos;
   logic              sample_en, shift_en, left_done, right_done;
   logic              pop, full, push, ovf_set, bypass;

   // Clock divider and bit counter; disabled interface parks everything at zero.
   always_comb begin
      div_d = '0;
      bit_d = '0;
      if (enable) begin
         bit_d = bit_q;
         if (div_q == DIV_LAST) begin
            bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   // Position within the slot; p=0 carries the LSB of the previous slot's word.
   always_comb begin
      pos        = (bit_q >= SLOT_POS) ? bit_q - SLOT_POS : bit_q;
      sample_en  = enable && (div_q == DIV_SAMPLE);
      shift_en   = sample_en && (((pos != '0) && (pos <= DATA_POS)) || ((pos == '0) && LSB_WRAPS));
      shift_d    = shift_en ? {shift_q[DATA_W-2:0], AUD_ADCDAT} : shift_q;
      left_done  = sample_en && (bit_q == SLOT_POS);
      right_done = sample_en && (bit_q == '0);
      pend_d     = right_done && !warm_q;
      warm_d     = !enable ? 1'b1 : (right_done ? 1'b0 : warm_q);
   end

   always_comb begin
      mono_w  = mono_mix(left_q, shift_q);
      pop     = valid_q && out_ready;
      full    = (count_q == DEPTH_LVL);
      push    = pend_q && (!full || pop);
      ovf_set = pend_q && full && !pop;
      wr_d    = push ? wr_q + 1'b1 : wr_q;
      rd_d    = pop ? rd_q + 1'b1 : rd_q;
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
      bypass  = push && (wr_q == rd_d);
      head_l  = bypass ? left_q  : mem_l_q[rd_d];
      head_r  = bypass ? shift_q : mem_r_q[rd_d];
      head_m  = bypass ? mono_w  : mem_m_q[rd_d];
      ovf_d   = ovf_set ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q   <= '0;
         bit_q   <= '0;
         bclk_q  <= 1'b0;
         lrck_q  <= 1'b0;
         warm_q  <= 1'b1;
         pend_q  <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         out_l_q <= '0;
         out_r_q <= '0;
         out_m_q <= '0;
      end else begin
         div_q   <= div_d;
         bit_q   <= bit_d;
         bclk_q  <= (div_d >= DIV_HALF);
         lrck_q  <= (bit_d >= SLOT_POS);
         warm_q  <= warm_d;
         pend_q  <= pend_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         valid_q <= (count_d != '0);
         ovf_q   <= ovf_d;
         if (count_d != '0) begin
            out_l_q <= head_l;
            out_r_q <= head_r;
            out_m_q <= head_m;
         end
      end
   end

   // Datapath storage carries no reset; the control above decides what is valid.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      if (left_done) begin
         left_q <= shift_d;
      end
      if (push) begin
         mem_l_q[wr_q] <= left_q;
         mem_r_q[wr_q] <= shift_q;
         mem_m_q[wr_q] <= mono_w;
      end
   end

   assign AUD_BCLK    = bclk_q;
   assign AUD_ADCLRCK = lrck_q;
   assign out_valid   = valid_q;
   assign out_left    = out_l_q;
   assign out_right   = out_r_q;
   assign out_mono    = out_m_q;
   assign fifo_level  = count_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_audio_adc_i2s_receiver.sv
// Directed bench for audio_adc_i2s_receiver: a WM8731-style codec model follows BCLK/ADCLRCK
// and serialises the bench's left/right words; results are checked with immediate assertions.
module tb_audio_adc_i2s_receiver;

   logic        clk = 1'b0;
   logic        reset, enable, adcdat, out_ready, clr_overflow;
   logic        bclk, lrck, out_valid, overflow;
   logic [15:0] out_left, out_right, out_mono;
   logic [2:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   logic [15:0] codec_l, codec_r, cur_l, cur_r;
   logic        prev_bclk, prev_lrck, cur_bit;
   bit          glitch_en;
   int          cp;

   always #5 clk = ~clk;

   audio_adc_i2s_receiver dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .AUD_ADCDAT   (adcdat),
      .AUD_BCLK     (bclk),
      .AUD_ADCLRCK  (lrck),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_left     (out_left),
      .out_right    (out_right),
      .out_mono     (out_mono),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   // Codec: new bit after each BCLK fall, MSB one BCLK after an LRCK change, words latched at frame start.
   // With glitch_en the bit is inverted while BCLK is low and corrected when BCLK rises.
   always @(negedge clk) begin
      if (reset || !enable) begin
         cp = 0; prev_bclk = 1'b0; prev_lrck = 1'b0;
         cur_l = codec_l; cur_r = codec_r; cur_bit = 1'b0; adcdat = 1'b0;
      end else begin
         if (prev_bclk && !bclk) begin
            if (lrck != prev_lrck) begin
               cp = 0;
               if (!lrck) begin
                  cur_bit = cur_r[0];
                  cur_l = codec_l;
                  cur_r = codec_r;
               end else begin
                  cur_bit = cur_l[0];
               end
            end else begin
               cp++;
               cur_bit = lrck ? cur_r[16-cp] : cur_l[16-cp];
            end
            adcdat = glitch_en ? ~cur_bit : cur_bit;
         end else if (!prev_bclk && bclk) begin
            adcdat = cur_bit;
         end
         prev_bclk = bclk;
         prev_lrck = lrck;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag, input int max);
      int n = 0;
      while (out_valid !== 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'b0, out_valid}, 32'd1);
   endtask

   // Returns the next head pair; with out_ready high it has been popped on return.
   task automatic wait_pair(input string tag, output logic [15:0] l, output logic [15:0] r,
                            output logic [15:0] m);
      wait_valid(tag, 600);
      l = out_left;
      r = out_right;
      m = out_mono;
      @(negedge clk);
   endtask

   // Waits for the next LRCK rise so the new words apply from the following frame.
   task automatic set_words(input logic [15:0] l, input logic [15:0] r);
      int n = 0;
      while (lrck !== 1'b0 && n < 600) begin @(negedge clk); n++; end
      while (lrck !== 1'b1 && n < 600) begin @(negedge clk); n++; end
      chk("lrck_rise", {31'b0, lrck}, 32'd1);
      codec_l = l;
      codec_r = r;
   endtask

   logic [15:0] pl, pr, pm;
   logic [15:0] dl [6];
   logic [15:0] dr [6];
   int bclk_err, lrck_err, v_err, park_err, n;

   initial begin
      reset = 1'b1; enable = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
      glitch_en = 1'b0; codec_l = 16'h1234; codec_r = 16'hA5C3;
      dl = '{16'h1111, 16'h3333, 16'h5555, 16'h7777, 16'h9999, 16'hBBBB};
      dr = '{16'h2222, 16'h4444, 16'h6666, 16'h8888, 16'hAAAA, 16'hCCCC};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_level", {29'b0, fifo_level}, 32'd0);
      chk("rst_left", {16'b0, out_left}, 32'd0);
      chk("rst_clocks", {30'b0, bclk, lrck}, 32'd0);
      chk("rst_overflow", {31'b0, overflow}, 32'd0);

      // Clock waveforms, warm-up discard, first pairs at 264 and 520 clk after enable
      reset = 1'b0; enable = 1'b1; out_ready = 1'b1; glitch_en = 1'b1;
      bclk_err = 0; lrck_err = 0; v_err = 0;
      for (int k = 1; k <= 600; k++) begin
         @(negedge clk);
         if (bclk !== ((k % 8) >= 4)) bclk_err++;
         if (lrck !== (((k / 8) % 32) >= 16)) lrck_err++;
         if (out_valid !== ((k == 264) || (k == 520))) v_err++;
         if (k == 264) begin
            chk("p1_left", {16'b0, out_left}, 32'h1234);
            chk("p1_right", {16'b0, out_right}, 32'hA5C3);
            chk("p1_mono", {16'b0, out_mono}, 32'hDBFB);
            chk("p1_level", {29'b0, fifo_level}, 32'd1);
         end
         if (k == 520) chk("p2_left", {16'b0, out_left}, 32'h1234);
      end
      chk("bclk_wave", bclk_err, 0);
      chk("lrck_wave", lrck_err, 0);
      chk("valid_timing", v_err, 0);

      // Mono boundary cases
      set_words(16'h7FFF, 16'h7FFF);
      wait_pair("mono_a_old", pl, pr, pm);
      wait_pair("mono_a", pl, pr, pm);
      chk("mono_7fff", {16'b0, pm}, 32'h7FFF);
      set_words(16'h8000, 16'h8000);
      wait_pair("mono_b_old", pl, pr, pm);
      wait_pair("mono_b", pl, pr, pm);
      chk("mono_8000", {16'b0, pm}, 32'h8000);
      set_words(16'hFFFF, 16'h0000);
      wait_pair("mono_c_old", pl, pr, pm);
      wait_pair("mono_c", pl, pr, pm);
      chk("mono_ffff", {16'b0, pm}, 32'hFFFF);
      chk("right_0000", {16'b0, pr}, 32'h0000);

      // Backpressure for six frames: four kept in order, two dropped, overflow sticky
      set_words(dl[0], dr[0]);
      wait_pair("ovf_sync", pl, pr, pm);
      out_ready = 1'b0;
      for (int i = 1; i < 6; i++) set_words(dl[i], dr[i]);
      repeat (450) @(negedge clk);
      chk("ovf_level", {29'b0, fifo_level}, 32'd4);
      chk("ovf_flag", {31'b0, overflow}, 32'd1);
      chk("ovf_head_mono", {16'b0, out_mono}, 32'h1999);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_left", {16'b0, out_left}, {16'b0, dl[i]});
         chk("drain_right", {16'b0, out_right}, {16'b0, dr[i]});
         @(negedge clk);
      end
      chk("drain_empty", {28'b0, out_valid, fifo_level}, 32'd0);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      chk("ovf_clear", {31'b0, overflow}, 32'd0);

      // Enable dropped mid-left-slot with one entry queued
      set_words(16'hCAFE, 16'h0123);
      wait_pair("en_old", pl, pr, pm);
      wait_pair("en_sync", pl, pr, pm);
      out_ready = 1'b0;
      wait_valid("en_queue", 600);
      repeat (40) @(negedge clk);
      enable = 1'b0;
      codec_l = 16'h4321; codec_r = 16'h8765;
      @(negedge clk);
      chk("park_clocks", {30'b0, bclk, lrck}, 32'd0);
      chk("park_level", {29'b0, fifo_level}, 32'd1);
      park_err = 0;
      repeat (100) begin
         @(negedge clk);
         if (bclk !== 1'b0 || lrck !== 1'b0 || fifo_level !== 3'd1) park_err++;
      end
      chk("park_hold", park_err, 0);
      enable = 1'b1;
      for (int k = 1; k <= 264; k++) begin
         @(negedge clk);
         if (k == 263) chk("restart_warmup", {29'b0, fifo_level}, 32'd1);
      end
      chk("restart_push", {29'b0, fifo_level}, 32'd2);
      out_ready = 1'b1;
      chk("kept_left", {16'b0, out_left}, 32'hCAFE);
      @(negedge clk);
      chk("new_left", {16'b0, out_left}, 32'h4321);
      chk("new_right", {16'b0, out_right}, 32'h8765);
      @(negedge clk);
      out_ready = 1'b0;

      // Asynchronous reset mid-right-slot with two entries queued
      n = 0;
      while (fifo_level !== 3'd2 && n < 700) begin @(negedge clk); n++; end
      chk("two_queued", {29'b0, fifo_level}, 32'd2);
      n = 0;
      while (lrck !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      repeat (20) @(negedge clk);
      chk("right_slot", {31'b0, lrck}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_level", {29'b0, fifo_level}, 32'd0);
      chk("arst_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_data", {out_left, out_right}, 32'd0);
      chk("arst_mono", {16'b0, out_mono}, 32'd0);
      chk("arst_clocks", {30'b0, bclk, lrck}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
